// File: rtl/bit_penceresi_besleyici.sv
// bit_penceresi_besleyici
// Feeds the bit-extraction stage of the JPEG entropy-decode path. It takes the
// compressed scan one byte at a time and removes 0xFF00 byte stuffing. It
// detects markers, and keeps an MSB-aligned bit window that downstream consumes
// N bits at a time.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   bayt_i               incoming compressed byte
//   bayt_gecerli_i       bayt_i valid
//   bayt_hazir_o         a byte can be accepted this cycle
//   tuket_en_i           consume request
//   tuket_n_i            number of bits to consume, 1..MAX_TUKET
//   pencere_o            bit window; the oldest bit is at the MSB
//   gecerli_bit_o        number of valid bits in the window, 0..32
//   pencere_gecerli_o    at least 16 valid bits, or marker padding active
//   marker_o             marker code byte that followed 0xFF
//   marker_gecerli_o     marker detected; held until marker_temizle_i
//   marker_temizle_i     clear the marker, flush the window, resume
//   hata_o               one-cycle pulse on an illegal consume request
//
// Optional feature macro: BIT_PENCERE_DOLGU_EN
//   When defined, the block appends 0xFF pad bytes in the MARKER state while
//   the count is 24 or less. Downstream can then finish the last code past the
//   end of the scan, following the JPEG 1-fill convention.

module bit_penceresi_besleyici #(
    parameter int PENCERE_W = 32,
    parameter int MAX_TUKET = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           bayt_i,
    input  logic                 bayt_gecerli_i,
    output logic                 bayt_hazir_o,
    input  logic                 tuket_en_i,
    input  logic [4:0]           tuket_n_i,
    output logic [PENCERE_W-1:0] pencere_o,
    output logic [5:0]           gecerli_bit_o,
    output logic                 pencere_gecerli_o,
    output logic [7:0]           marker_o,
    output logic                 marker_gecerli_o,
    input  logic                 marker_temizle_i,
    output logic                 hata_o
);

    typedef enum logic [1:0] {
        NORMAL,
        FF_BEKLE,
        MARKER
    } durum_t;

    localparam logic [4:0] MAX_N = 5'(MAX_TUKET);

    durum_t               durum_q, durum_d;
    logic [PENCERE_W-1:0] pencere_q, pencere_d;
    logic [5:0]           sayac_q, sayac_d;
    logic [7:0]           marker_q, marker_d;
    logic                 marker_gecerli_q, marker_gecerli_d;
    logic                 hata_q, hata_d;
    logic                 hazir_q, hazir_d;
    logic                 pgecerli_q, pgecerli_d;

    // Intermediate window and count after the consume. A byte appended in
    // the same cycle lands directly below the bits that are still valid.
    logic [PENCERE_W-1:0] pencere_ara;
    logic [5:0]           sayac_ara;
    logic                 bayt_kabul;
    logic                 temizle;
    logic                 tuket_yasal;

    // State and all outputs are registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q          <= NORMAL;
            pencere_q        <= '0;
            sayac_q          <= '0;
            marker_q         <= '0;
            marker_gecerli_q <= 1'b0;
            hata_q           <= 1'b0;
            hazir_q          <= 1'b0;
            pgecerli_q       <= 1'b0;
        end else begin
            durum_q          <= durum_d;
            pencere_q        <= pencere_d;
            sayac_q          <= sayac_d;
            marker_q         <= marker_d;
            marker_gecerli_q <= marker_gecerli_d;
            hata_q           <= hata_d;
            hazir_q          <= hazir_d;
            pgecerli_q       <= pgecerli_d;
        end
    end

    // Next state. The order is: a marker clear (which wins over everything),
    // then the consume shift, then the byte append or the pad append.
    always_comb begin
        durum_d          = durum_q;
        pencere_d        = pencere_q;
        sayac_d          = sayac_q;
        marker_d         = marker_q;
        marker_gecerli_d = marker_gecerli_q;
        hata_d           = 1'b0;
        pencere_ara      = pencere_q;
        sayac_ara        = sayac_q;

        // hazir_q already reflects the pre-consume count of this cycle.
        bayt_kabul  = bayt_gecerli_i && hazir_q;
        temizle     = marker_temizle_i && (durum_q == MARKER);
        tuket_yasal = (tuket_n_i != 5'd0) && (tuket_n_i <= MAX_N)
                      && ({1'b0, tuket_n_i} <= sayac_q);

        if (temizle) begin
            pencere_d        = '0;
            sayac_d          = '0;
            marker_gecerli_d = 1'b0;
            durum_d          = NORMAL;
        end else begin
            if (tuket_en_i) begin
                if (tuket_yasal) begin
                    pencere_ara = pencere_q << tuket_n_i;
                    sayac_ara   = sayac_q - {1'b0, tuket_n_i};
                end else begin
                    hata_d = 1'b1;
                end
            end
            pencere_d = pencere_ara;
            sayac_d   = sayac_ara;

            if (bayt_kabul) begin
                case (durum_q)
                    NORMAL: begin
                        if (bayt_i == 8'hFF) begin
                            durum_d = FF_BEKLE;
                        end else begin
                            pencere_d = pencere_ara | ({bayt_i, 24'h0} >> sayac_ara);
                            sayac_d   = sayac_ara + 6'd8;
                        end
                    end
                    FF_BEKLE: begin
                        if (bayt_i == 8'h00) begin
                            pencere_d = pencere_ara | ({8'hFF, 24'h0} >> sayac_ara);
                            sayac_d   = sayac_ara + 6'd8;
                            durum_d   = NORMAL;
                        end else if (bayt_i != 8'hFF) begin
                            // Consecutive 0xFF bytes are fill, so a marker
                            // starts only at a byte other than 0x00 or 0xFF.
                            marker_d         = bayt_i;
                            marker_gecerli_d = 1'b1;
                            durum_d          = MARKER;
                        end
                    end
                    default: begin
                    end
                endcase
            end

`ifdef BIT_PENCERE_DOLGU_EN
            // Once the scan has ended, the window is kept topped up with ones.
            if ((durum_q == MARKER) && (sayac_ara <= 6'd24)) begin
                pencere_d = pencere_ara | ({8'hFF, 24'h0} >> sayac_ara);
                sayac_d   = sayac_ara + 6'd8;
            end
`endif
        end

        hazir_d = (durum_d != MARKER) && (sayac_d <= 6'd24);
`ifdef BIT_PENCERE_DOLGU_EN
        pgecerli_d = (sayac_d >= 6'd16) || (durum_d == MARKER);
`else
        pgecerli_d = (sayac_d >= 6'd16);
`endif
    end

    assign pencere_o         = pencere_q;
    assign gecerli_bit_o     = sayac_q;
    assign pencere_gecerli_o = pgecerli_q;
    assign marker_o          = marker_q;
    assign marker_gecerli_o  = marker_gecerli_q;
    assign hata_o            = hata_q;
    assign bayt_hazir_o      = hazir_q;

endmodule

// File: tb/tb_bit_penceresi_besleyici.sv
// Testbench for bit_penceresi_besleyici.
// The bench uses a table of {stimulus, expected outputs} records. Each record
// is pushed to a scoreboard queue when it is driven. It is then popped and
// compared one clock later, once the registered outputs have updated.

module tb_bit_penceresi_besleyici;

`ifdef BIT_PENCERE_DOLGU_EN
    localparam bit DOLGU = 1'b1;
`else
    localparam bit DOLGU = 1'b0;
`endif

    typedef struct {
        bit          rs;
        bit          bv;
        logic [7:0]  b;
        bit          te;
        logic [4:0]  n;
        bit          clr;
        logic [31:0] win;
        logic [5:0]  cnt;
        bit          hz;
        bit          pg;
        bit          ht;
        bit          mg;
        logic [7:0]  mk;
        int          id;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic [7:0]  bayt;
    logic        baytGecerli;
    logic        baytHazir;
    logic        tuketEn;
    logic [4:0]  tuketN;
    logic [31:0] pencere;
    logic [5:0]  gecerliBit;
    logic        pencereGecerli;
    logic [7:0]  marker;
    logic        markerGecerli;
    logic        markerTemizle;
    logic        hata;

    int   passCount  = 0;
    int   checkCount = 0;
    vec_t tbl[$];
    vec_t sb[$];

    bit_penceresi_besleyici dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .bayt_i            (bayt),
        .bayt_gecerli_i    (baytGecerli),
        .bayt_hazir_o      (baytHazir),
        .tuket_en_i        (tuketEn),
        .tuket_n_i         (tuketN),
        .pencere_o         (pencere),
        .gecerli_bit_o     (gecerliBit),
        .pencere_gecerli_o (pencereGecerli),
        .marker_o          (marker),
        .marker_gecerli_o  (markerGecerli),
        .marker_temizle_i  (markerTemizle),
        .hata_o            (hata)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t v(bit rs, bit bv, logic [7:0] b, bit te, logic [4:0] n,
                               bit clr, logic [31:0] win, logic [5:0] cnt, bit hz,
                               bit pg, bit ht, bit mg, logic [7:0] mk);
        vec_t r;
        r.rs = rs; r.bv = bv; r.b = b; r.te = te; r.n = n; r.clr = clr;
        r.win = win; r.cnt = cnt; r.hz = hz; r.pg = pg; r.ht = ht;
        r.mg = mg; r.mk = mk; r.id = 0;
        return r;
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive all inputs to idle
    task automatic idleInputs();
        bayt          = 8'h00;
        baytGecerli   = 1'b0;
        tuketEn       = 1'b0;
        tuketN        = 5'd0;
        markerTemizle = 1'b0;
    endtask

    // Assert reset between clock edges and check that the outputs clear
    // immediately. Then release reset and check that ready rises on the
    // first clock after release.
    task automatic doReset();
        @(negedge clk);
        idleInputs();
        rstN = 1'b0;
        #1;
        compare("rst.pencere", pencere, 32'h0);
        compare("rst.count", {26'h0, gecerliBit}, 32'h0);
        compare("rst.hazir", {31'h0, baytHazir}, 32'h0);
        compare("rst.pgecerli", {31'h0, pencereGecerli}, 32'h0);
        compare("rst.hata", {31'h0, hata}, 32'h0);
        compare("rst.mgecerli", {31'h0, markerGecerli}, 32'h0);
        compare("rst.marker", {24'h0, marker}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        compare("rst.hazirRelease", {31'h0, baytHazir}, 32'h1);
        compare("rst.pencereRelease", pencere, 32'h0);
    endtask

    // Pop one expected record from the scoreboard and compare every output
    task automatic checkOutput();
        vec_t e;
        string p;
        if (sb.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        p = $sformatf("v%0d", e.id);
        compare({p, ".pencere"}, pencere, e.win);
        compare({p, ".count"}, {26'h0, gecerliBit}, {26'h0, e.cnt});
        compare({p, ".hazir"}, {31'h0, baytHazir}, {31'h0, e.hz});
        compare({p, ".pgecerli"}, {31'h0, pencereGecerli}, {31'h0, e.pg});
        compare({p, ".hata"}, {31'h0, hata}, {31'h0, e.ht});
        compare({p, ".mgecerli"}, {31'h0, markerGecerli}, {31'h0, e.mg});
        compare({p, ".marker"}, {24'h0, marker}, {24'h0, e.mk});
    endtask

    // Drive one record for one clock. Push its expectation, then compare
    // just after the active edge.
    task automatic applyStimulus(vec_t r);
        @(negedge clk);
        bayt          = r.b;
        baytGecerli   = r.bv;
        tuketEn       = r.te;
        tuketN        = r.n;
        markerTemizle = r.clr;
        sb.push_back(r);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t h;
        rstN = 1'b1;
        idleInputs();

        // Sequence A: fill, consume, illegal consumes, consume and byte together
        tbl.push_back(v(1, 1, 8'hA5, 0, 0,  0, 32'hA5000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h3C, 0, 0,  0, 32'hA53C0000, 16, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h0F, 0, 0,  0, 32'hA53C0F00, 24, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hF0, 0, 0,  0, 32'hA53C0FF0, 32, 0, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 5,  0, 32'hA781FE00, 27, 0, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 3,  0, 32'h3C0FF000, 24, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 16, 0, 32'hF0000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 9,  0, 32'hF0000000, 8,  1, 0, 1, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 0, 0,  0, 32'hF0000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 0,  0, 32'hF0000000, 8,  1, 0, 1, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h11, 0, 0,  0, 32'hF0110000, 16, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h22, 0, 0,  0, 32'hF0112200, 24, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 17, 0, 32'hF0112200, 24, 1, 1, 1, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h77, 1, 4,  0, 32'h01122770, 28, 0, 1, 0, 0, 8'h00));

        // Sequence B: stuffing removal and fill bytes (reset arrives mid-stream)
        tbl.push_back(v(1, 1, 8'h12, 0, 0, 0, 32'h12000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hFF, 0, 0, 0, 32'h12000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h00, 0, 0, 0, 32'h12FF0000, 16, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h34, 0, 0, 0, 32'h12FF3400, 24, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hFF, 0, 0, 0, 32'h12FF3400, 24, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hFF, 0, 0, 0, 32'h12FF3400, 24, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h00, 0, 0, 0, 32'h12FF34FF, 32, 0, 1, 0, 0, 8'h00));

        // Sequence C: marker detection, behaviour in MARKER, clear together with consume
        tbl.push_back(v(1, 1, 8'hAB, 0, 0, 0, 32'hAB000000, 8, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hFF, 0, 0, 0, 32'hAB000000, 8, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hFF, 0, 0, 0, 32'hAB000000, 8, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hD9, 0, 0, 0, 32'hAB000000, 8, 0, DOLGU, 0, 1, 8'hD9));
        tbl.push_back(v(0, 1, 8'h55, 0, 0, 0, DOLGU ? 32'hABFF0000 : 32'hAB000000,
                        DOLGU ? 6'd16 : 6'd8, 0, DOLGU, 0, 1, 8'hD9));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, DOLGU ? 32'hABFFFF00 : 32'hAB000000,
                        DOLGU ? 6'd24 : 6'd8, 0, DOLGU, 0, 1, 8'hD9));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, DOLGU ? 32'hABFFFFFF : 32'hAB000000,
                        DOLGU ? 6'd32 : 6'd8, 0, DOLGU, 0, 1, 8'hD9));
        tbl.push_back(v(0, 0, 8'h00, 1, 4, 0, DOLGU ? 32'hBFFFFFF0 : 32'hB0000000,
                        DOLGU ? 6'd28 : 6'd4, 0, DOLGU, 0, 1, 8'hD9));
        tbl.push_back(v(0, 0, 8'h00, 1, 2, 1, 32'h00000000, 0,  1, 0, 0, 0, 8'hD9));
        tbl.push_back(v(0, 1, 8'h5A, 0, 0, 0, 32'h5A000000, 8,  1, 0, 0, 0, 8'hD9));
        tbl.push_back(v(0, 1, 8'h66, 0, 0, 1, 32'h5A660000, 16, 1, 1, 0, 0, 8'hD9));

        // Sequence D: a pending 0xFF is discarded by reset
        tbl.push_back(v(1, 1, 8'h12, 0, 0, 0, 32'h12000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'hFF, 0, 0, 0, 32'h12000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 1, 8'h00, 0, 0, 0, 32'h00000000, 8,  1, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 1, 8'h81, 0, 0, 0, 32'h00810000, 16, 1, 1, 0, 0, 8'h00));

        $display("[TB] running %0d table vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t r;
            r = tbl[i];
            r.id = i;
            if (r.rs) doReset();
            applyStimulus(r);
        end

        // Hand sequence: the count is 3 and a 5-bit consume is refused.
        // hata pulses for exactly one cycle.
        doReset();
        h = v(0, 1, 8'hE7, 0, 0, 0, 32'hE7000000, 8, 1, 0, 0, 0, 8'h00); h.id = 100;
        applyStimulus(h);
        h = v(0, 0, 8'h00, 1, 5, 0, 32'hE0000000, 3, 1, 0, 0, 0, 8'h00); h.id = 101;
        applyStimulus(h);
        h = v(0, 0, 8'h00, 1, 5, 0, 32'hE0000000, 3, 1, 0, 1, 0, 8'h00); h.id = 102;
        applyStimulus(h);
        h = v(0, 0, 8'h00, 0, 0, 0, 32'hE0000000, 3, 1, 0, 0, 0, 8'h00); h.id = 103;
        applyStimulus(h);
        h = v(0, 0, 8'h00, 1, 3, 0, 32'h00000000, 0, 1, 0, 0, 0, 8'h00); h.id = 104;
        applyStimulus(h);

        @(negedge clk);
        idleInputs();
        compare("scoreboard.drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
